// File: rtl/shwr_pdt_reader.sv
// PDT-side reader for the shower-buffer memory mux: streams one full buffer trace,
// starting at a trigger offset, while yielding the memory to DMA on request.
module shwr_pdt_reader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int BUF_AW     = 11,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [ADDR_WIDTH-BUF_AW-1:0] i_buf_num,
    input  logic [BUF_AW-1:0]            i_start_offs,
    input  logic                         i_abort,
    input  logic                         i_dma_req,
    output logic                         o_sel_b,
    output logic [ADDR_WIDTH-1:0]        o_addr_b,
    output logic                         o_ena_b,
    input  logic [DATA_WIDTH-1:0]        i_rd_data,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int BW = ADDR_WIDTH - BUF_AW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [BUF_AW:0] TRACE_LEN = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [CW:0]     DEPTH     = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_SETTLE, S_READ, S_YIELD, S_DRAIN, S_ABORT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BW-1:0]         r_buf;
    logic [BUF_AW-1:0]     r_offs;
    logic [BUF_AW:0]       r_issue_cnt;
    logic [BUF_AW:0]       r_out_cnt;
    logic [CW-1:0]         r_inflight;
    logic [RD_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_credit;
    logic                  w_all_issued;
    logic                  w_inflight_zero;
    logic                  w_trace_done;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_flush;
    logic                  w_accept_start;
    logic [BUF_AW-1:0]     w_rd_offs;

    // Credit counts words still in the memory pipeline so every return has a FIFO slot.
    assign w_credit        = ({1'b0, r_inflight} + {1'b0, r_count}) < DEPTH;
    assign w_all_issued    = r_issue_cnt[BUF_AW];
    assign w_inflight_zero = (r_inflight == '0);
    assign w_trace_done    = (r_out_cnt == TRACE_LEN);
    assign w_wr            = r_vld[RD_LATENCY-1];
    assign w_rd            = o_out_valid & i_out_ready;
    assign w_flush         = (r_state == S_ABORT) & w_inflight_zero;
    assign w_accept_start  = (r_state == S_IDLE) & i_start;
    assign w_rd_offs       = r_offs + r_issue_cnt[BUF_AW-1:0];

    assign o_addr_b    = o_ena_b ? {r_buf, w_rd_offs} : '0;
    assign o_out_valid = (r_count != '0);
    assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_GRANT;
            S_GRANT:  if (i_abort) w_next = S_ABORT;
                      else if (!i_dma_req) w_next = S_SETTLE;
            S_SETTLE: w_next = i_abort ? S_ABORT : S_READ;
            S_READ:   if (i_abort) w_next = S_ABORT;
                      else if (w_all_issued) w_next = S_DRAIN;
                      else if (i_dma_req) w_next = S_YIELD;
            S_YIELD:  if (i_abort) w_next = S_ABORT;
                      else if (w_inflight_zero) w_next = S_GRANT;
            S_DRAIN:  if (i_abort) w_next = S_ABORT;
                      else if (w_trace_done && w_inflight_zero) w_next = S_IDLE;
            S_ABORT:  if (w_inflight_zero) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_sel_b = 1'b0;
        o_ena_b = 1'b0;
        o_done  = 1'b0;
        o_busy  = (r_state != S_IDLE);
        case (r_state)
            S_SETTLE: o_sel_b = 1'b1;
            S_READ: begin
                o_sel_b = 1'b1;
                o_ena_b = w_credit & ~w_all_issued & ~i_dma_req & ~i_abort;
            end
            S_YIELD:  o_sel_b = ~w_inflight_zero;
            S_DRAIN: begin
                o_sel_b = ~w_inflight_zero;
                o_done  = w_trace_done & w_inflight_zero & ~i_abort;
            end
            S_ABORT: begin
                o_sel_b = ~w_inflight_zero;
                o_done  = w_inflight_zero;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf       <= '0;
            r_offs      <= '0;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= '0;
            r_vld       <= '0;
        end else begin
            if (w_accept_start) begin
                r_buf       <= i_buf_num;
                r_offs      <= i_start_offs;
                r_issue_cnt <= '0;
                r_out_cnt   <= '0;
            end else begin
                if (o_ena_b) r_issue_cnt <= r_issue_cnt + (BUF_AW+1)'(1);
                if (w_rd)    r_out_cnt   <= r_out_cnt + (BUF_AW+1)'(1);
            end
            case ({o_ena_b, w_wr})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            r_vld[0] <= o_ena_b;
            for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // Output FIFO; only the pointers and count are reset, the storage is not.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_rd_data;
    end

endmodule

// File: tb/tb_shwr_pdt_reader.sv
// Directed bench for shwr_pdt_reader: memory model with fixed read latency,
// stream/address monitor, and hand-derived expectations per scenario.
module tb_shwr_pdt_reader;

    localparam int AW  = 15;
    localparam int DW  = 32;
    localparam int BAW = 11;
    localparam int L   = 2;
    localparam int FD  = 8;
    localparam int NW  = 2048;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_abort, i_dma_req, i_out_ready;
    logic [3:0]    i_buf_num;
    logic [10:0]   i_start_offs;
    logic          o_sel_b, o_ena_b, o_out_valid, o_busy, o_done;
    logic [AW-1:0] o_addr_b;
    logic [DW-1:0] i_rd_data, o_out_data;

    always #5 clk = ~clk;

    shwr_pdt_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_AW(BAW), .RD_LATENCY(L), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_buf_num(i_buf_num),
        .i_start_offs(i_start_offs), .i_abort(i_abort), .i_dma_req(i_dma_req),
        .o_sel_b(o_sel_b), .o_addr_b(o_addr_b), .o_ena_b(o_ena_b), .i_rd_data(i_rd_data),
        .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    function automatic logic [31:0] mdat(input logic [14:0] a);
        return {a, ~a, 2'b01};
    endfunction

    // Memory model: data for the address presented L edges earlier.
    logic [AW-1:0] apipe [L];
    always @(posedge clk) begin
        apipe[0] <= o_addr_b;
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign i_rd_data = mdat(apipe[L-1]);

    int n_chk = 0;
    int n_err = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          rx_tot = 0, iss_tot = 0, done_tot = 0;
    int          data_err = 0, addr_err = 0, prot_err = 0, hold_err = 0, ena_dma = 0;
    int          rx_base = 0, iss_base = 0, done_base = 0;
    logic [3:0]  exp_buf = '0;
    logic [10:0] exp_offs = '0;
    logic [14:0] iss_addr [0:4095];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_ena_b) begin
                if (o_addr_b !== {exp_buf, 11'(exp_offs + 11'(iss_tot - iss_base))})
                    addr_err <= addr_err + 1;
                iss_addr[(iss_tot - iss_base) & 4095] <= o_addr_b;
                iss_tot <= iss_tot + 1;
                if (!o_sel_b)  prot_err <= prot_err + 1;
                if (i_dma_req) ena_dma  <= ena_dma + 1;
            end
            if (prev_stall && (!o_out_valid || o_out_data !== prev_data))
                hold_err <= hold_err + 1;
            if (o_out_valid && i_out_ready) begin
                if (o_out_data !== mdat({exp_buf, 11'(exp_offs + 11'(rx_tot - rx_base))}))
                    data_err <= data_err + 1;
                rx_tot <= rx_tot + 1;
            end
            if (o_done) done_tot <= done_tot + 1;
            prev_stall <= o_out_valid && !i_out_ready;
            prev_data  <= o_out_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic start_rd(input logic [3:0] b, input logic [10:0] o);
        @(posedge clk); #1;
        exp_buf = b; exp_offs = o;
        rx_base = rx_tot; iss_base = iss_tot; done_base = done_tot;
        i_buf_num = b; i_start_offs = o; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rx_tot - rx_base >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done_tot > done_base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic full_trace(input string tag);
        bit ok;
        wait_done(6000, ok);
        chk({tag, "_done"}, 32'(ok), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_words"}, rx_tot - rx_base, NW);
        chk({tag, "_issued"}, iss_tot - iss_base, NW);
        chk({tag, "_done_once"}, done_tot - done_base, 1);
        chk({tag, "_idle"}, {o_sel_b, o_ena_b, o_busy, o_out_valid}, 0);
        chk({tag, "_data_err"}, data_err, 0);
        chk({tag, "_addr_err"}, addr_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cnt;
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_dma_req = 1'b0;
        i_out_ready = 1'b1; i_buf_num = '0; i_start_offs = '0;
        #1;
        chk("rst_ctrl", {o_sel_b, o_ena_b, o_busy, o_done, o_out_valid}, 0);
        chk("rst_addr", o_addr_b, 0);
        chk("rst_data", o_out_data, 0);
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;

        // Buffer 3 from offset 0
        start_rd(4'd3, 11'h000);
        full_trace("t1");
        chk("t1_first_addr", iss_addr[0], 15'h1800);
        chk("t1_last_addr", iss_addr[NW-1], 15'h1FFF);

        // Offset wrap inside buffer 0
        start_rd(4'd0, 11'h7F0);
        full_trace("t2");
        chk("t2_first_addr", iss_addr[0], 15'h07F0);
        chk("t2_top_addr", iss_addr[15], 15'h07FF);
        chk("t2_wrap_addr", iss_addr[16], 15'h0000);
        chk("t2_last_addr", iss_addr[NW-1], 15'h07EF);

        // Consumer stalled: credit limits issue to FIFO depth
        i_out_ready = 1'b0;
        start_rd(4'd1, 11'h005);
        repeat (40) @(negedge clk);
        chk("t3_issued_stall", iss_tot - iss_base, FD);
        chk("t3_valid", o_out_valid, 1);
        chk("t3_head", o_out_data, mdat(15'h0805));
        chk("t3_none_taken", rx_tot - rx_base, 0);
        @(posedge clk); #1 i_out_ready = 1'b1;
        full_trace("t3");
        chk("t3_hold_err", hold_err, 0);

        // DMA takes the memory for 20 cycles around word 100
        start_rd(4'd2, 11'h100);
        wait_rx(100, 500, ok);
        chk("t4_reach_100", 32'(ok), 1);
        @(posedge clk); #1 i_dma_req = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_sel_b) break;
            cnt++;
        end
        chk("t4_sel_fall", cnt, L);
        repeat (20 - cnt - 1) @(posedge clk);
        @(posedge clk); #1 i_dma_req = 1'b0;
        @(negedge clk);
        chk("t4_grant", {o_sel_b, o_ena_b}, 2'b00);
        @(negedge clk);
        chk("t4_settle", {o_sel_b, o_ena_b}, 2'b10);
        @(negedge clk);
        chk("t4_resume", {o_sel_b, o_ena_b}, 2'b11);
        full_trace("t4");
        chk("t4_ena_in_dma", ena_dma, 0);
        chk("t4_prot", prot_err, 0);

        // Abort near word 500, then a clean full readout
        start_rd(4'd1, 11'h000);
        wait_rx(500, 1000, ok);
        chk("t5_reach_500", 32'(ok), 1);
        @(posedge clk); #1 i_abort = 1'b1;
        @(negedge clk);
        cnt = o_sel_b ? 1 : 0;
        @(posedge clk); #1 i_abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_sel_b) break;
            cnt++;
        end
        chk("t5_sel_drop", 32'(cnt <= L + 1), 1);
        wait_done(20, ok);
        chk("t5_done", 32'(ok), 1);
        repeat (2) @(negedge clk);
        chk("t5_flushed", {o_out_valid, o_busy, o_sel_b}, 0);
        chk("t5_done_once", done_tot - done_base, 1);
        chk("t5_partial", 32'(rx_tot - rx_base < NW), 1);
        start_rd(4'd1, 11'h010);
        full_trace("t5b");

        // Asynchronous reset mid-readout
        start_rd(4'd3, 11'h020);
        wait_rx(50, 500, ok);
        chk("t6_reach_50", 32'(ok), 1);
        @(negedge clk); #2 i_rst = 1'b1;
        #1;
        chk("t6_async_ctrl", {o_sel_b, o_ena_b, o_busy, o_done, o_out_valid}, 0);
        chk("t6_async_addr", o_addr_b, 0);
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        start_rd(4'd2, 11'h7FF);
        full_trace("t6");
        chk("t6_first_addr", iss_addr[0], 15'h17FF);
        chk("t6_wrap_addr", iss_addr[1], 15'h1000);
        chk("t6_prot", prot_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
